// File: rtl/fft_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for a streaming FFT, ping-pong banked.
// Define FFT_REORDER_STATUS_EN to add the sticky overflow flag and the emitted-frame counter.
module fft_bitrev_reorder #(
  parameter int FFT_N = 1024,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_sof,
  output logic          out_eof
`ifdef FFT_REORDER_STATUS_EN
  ,
  output logic          overflow,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int AW = $clog2(FFT_N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(FFT_N - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_LAST   = 2'd2;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  logic [2*DW-1:0] mem [2*FFT_N];

  logic          wbank_q, wbank_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    state_q, state_d;
  logic          rbank_q, rbank_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eof_q, out_eof_d;
  logic [2*DW-1:0] out_data_q;

  logic [AW-1:0] waddr;
  logic          accept, complete, xfer, drain, other_full, ld, ld_bank;
  logic [AW-1:0] ld_addr;

  assign in_ready = !full_q[wbank_q];

  always_comb begin
    accept   = in_valid & in_ready;
    waddr    = in_sof ? '0 : wcnt_q;
    complete = accept && (waddr == LAST_ADDR);
    wcnt_d   = accept ? waddr + 1'b1 : wcnt_q;

    xfer  = out_valid_q & out_ready;
    // In LAST the output register always holds bin FFT_N-1, so its transfer drains the bank.
    drain = (state_q == ST_LAST) && xfer;
    other_full = full_q[~rbank_q] | (complete & (wbank_q != rbank_q));

    full_d = full_q;
    if (complete) full_d[wbank_q] = 1'b1;
    if (drain)    full_d[rbank_q] = 1'b0;
    wbank_d = (full_d[wbank_q] && !full_d[~wbank_q]) ? ~wbank_q : wbank_q;

    state_d = state_q;
    rbank_d = rbank_q;
    rcnt_d  = rcnt_q;
    ld      = 1'b0;
    ld_bank = rbank_q;
    ld_addr = bitrev(rcnt_q);
    case (state_q)
      ST_IDLE: if (full_q[rbank_q]) state_d = ST_STREAM;
      ST_STREAM: begin
        if (!out_valid_q || out_ready) begin
          ld     = 1'b1;
          rcnt_d = rcnt_q + 1'b1;
          if (rcnt_q == LAST_ADDR) state_d = ST_LAST;
        end
      end
      ST_LAST: begin
        if (drain) begin
          rbank_d = ~rbank_q;
          if (other_full) begin
            // Start the next frame in the drain cycle so the stream has no bubble.
            ld      = 1'b1;
            ld_bank = ~rbank_q;
            ld_addr = '0;
            rcnt_d  = AW'(1);
            state_d = ST_STREAM;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = ld | (out_valid_q & !out_ready);
    out_sof_d   = ld ? (ld_addr == '0) : out_sof_q;
    out_eof_d   = ld ? (ld_addr == LAST_ADDR) : out_eof_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_q     <= 1'b0;
      wcnt_q      <= '0;
      full_q      <= 2'b00;
      state_q     <= ST_IDLE;
      rbank_q     <= 1'b0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      full_q      <= full_d;
      state_q     <= state_d;
      rbank_q     <= rbank_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[{wbank_q, waddr}] <= {in_re, in_im};
  end

  // Synchronous RAM read lands directly in the output register; it only loads when free.
  always_ff @(posedge clk) begin
    if (rst)     out_data_q <= '0;
    else if (ld) out_data_q <= mem[{ld_bank, ld_addr}];
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q & out_valid_q;
  assign out_eof   = out_eof_q & out_valid_q;
  assign out_re    = out_data_q[2*DW-1:DW];
  assign out_im    = out_data_q[DW-1:0];

`ifdef FFT_REORDER_STATUS_EN
  logic        overflow_q, overflow_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    overflow_d  = overflow_q | (in_valid & !in_ready);
    frame_cnt_d = drain ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder (FFT_N=8): random data against a frame-level reference model.
module tb_fft_bitrev_reorder;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_sof, in_ready, out_valid, out_ready, out_sof, out_eof;
  logic [DW-1:0] in_re, in_im, out_re, out_im;
`ifdef FFT_REORDER_STATUS_EN
  logic overflow;
  logic [15:0] frame_cnt;
`endif

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.FFT_N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sof(in_sof), .in_re(in_re), .in_im(in_im), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_sof(out_sof), .out_eof(out_eof)
`ifdef FFT_REORDER_STATUS_EN
    , .overflow(overflow), .frame_cnt(frame_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          sof;
    logic          eof;
  } smp_t;

  smp_t            exp_q[$];
  logic [2*DW-1:0] part[$];
  int              held;
  bit              m_ovf;
  int              m_fcnt;
  int              total, bad;
  bit              stall_prev;
  logic [2*DW+1:0] stall_val;

  function automatic int brev(int k);
    int r = 0;
    for (int i = 0; i < AW; i++) r |= ((k >> i) & 1) << (AW - 1 - i);
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    part.delete();
    held = 0;
    m_ovf = 0;
    m_fcnt = 0;
    stall_prev = 0;
  endtask

  // One clock: drive at the negedge, judge the coming edge just after, then advance.
  task automatic tick(bit v, bit s, logic [DW-1:0] re, logic [DW-1:0] im, bit rdy);
    bit   acc, drain;
    smp_t e;
    in_valid = v; in_sof = s; in_re = re; in_im = im; out_ready = rdy;
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (stall_prev)
        chk("stall_hold", {out_valid, out_re, out_im, out_sof, out_eof}, {1'b1, stall_val});
      chk("in_ready", in_ready, held < 2);
`ifdef FFT_REORDER_STATUS_EN
      chk("overflow", overflow, m_ovf);
      chk("frame_cnt", frame_cnt, m_fcnt & 16'hFFFF);
`endif
      acc = v && (held < 2);
      if (v && !acc) m_ovf = 1;
      drain = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_extra", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_sample", {out_re, out_im, out_sof, out_eof}, e);
          if (e.eof) begin drain = 1; m_fcnt++; end
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_re, out_im, out_sof, out_eof};
      if (acc) begin
        if (s) part.delete();
        part.push_back({re, im});
        if (part.size() == N) begin
          for (int k = 0; k < N; k++) begin
            e.re  = part[brev(k)][2*DW-1:DW];
            e.im  = part[brev(k)][DW-1:0];
            e.sof = (k == 0);
            e.eof = (k == N - 1);
            exp_q.push_back(e);
          end
          part.delete();
          held++;
        end
      end
      if (drain) held--;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(int base, bit rdy_toggle);
    for (int j = 0; j < N; j++)
      tick(1, j == 0, DW'(base + j), DW'($urandom), rdy_toggle ? (j % 2 == 0) : 1'b1);
  endtask

  task automatic drain_all(string tag, bit rnd, bit toggle);
    int i = 0;
    while (exp_q.size() > 0 && i < 400) begin
      tick(0, 0, '0, '0, rnd ? ($urandom_range(0, 3) != 0) : (toggle ? (i % 2 == 0) : 1'b1));
      i++;
    end
    for (int k = 0; k < 4; k++) tick(0, 0, '0, '0, 1);
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    total = 0; bad = 0;
    model_reset();
    rst = 1;
    tick(0, 0, '0, '0, 1);
    tick(0, 0, '0, '0, 1);
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", {out_re, out_im}, 0);
    chk("rst_out_flags", {out_sof, out_eof}, 0);

    // Single frame, natural order out, latency of two edges after the last input.
    send_frame(0, 0);
    chk("lat_edge0", out_valid, 0);
    tick(0, 0, '0, '0, 1);
    chk("lat_edge1", out_valid, 0);
    tick(0, 0, '0, '0, 1);
    chk("lat_edge2", out_valid, 1);
    chk("first_bin", {out_re, out_sof}, {16'd0, 1'b1});
    drain_all("t1_drain", 0, 0);

    // Three back-to-back frames, continuous output.
    for (int f = 0; f < 3; f++) send_frame(N * f, 0);
    drain_all("t2_drain", 0, 0);

    // Output backpressure toggling during and after the frame.
    send_frame(0, 1);
    drain_all("t3_drain", 0, 1);

    // Consumer stalled while three frames arrive: third frame is dropped.
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < N; j++) tick(1, j == 0, DW'(100 + N * f + j), DW'($urandom), 0);
    chk("t4_in_ready_low", in_ready, 0);
`ifdef FFT_REORDER_STATUS_EN
    chk("t4_overflow", overflow, 1);
`endif
    drain_all("t4_drain", 0, 0);

    // Restarted frame: partial of five samples is discarded.
    for (int j = 0; j < 5; j++) tick(1, j == 0, DW'(200 + j), DW'($urandom), 1);
    send_frame(300, 0);
    drain_all("t5_drain", 0, 0);

    // Random gaps on input, random backpressure on output.
    begin
      int j = 0;
      for (int c = 0; c < 200; c++) begin
        bit v = ($urandom_range(0, 3) != 0);
        tick(v, v && (j % N == 0), DW'($urandom), DW'($urandom), $urandom_range(0, 3) != 0);
        if (v) j++;
      end
    end
    drain_all("rand_drain", 1, 0);

    // Reset in the middle of output.
    send_frame(400, 0);
    tick(0, 0, '0, '0, 1);
    tick(0, 0, '0, '0, 1);
    tick(0, 0, '0, '0, 1);
    rst = 1;
    tick(0, 0, '0, '0, 1);
    rst = 0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
`ifdef FFT_REORDER_STATUS_EN
    chk("t6_overflow", overflow, 0);
    chk("t6_frame_cnt", frame_cnt, 0);
`endif
    send_frame(500, 0);
    drain_all("t6_drain", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
